// File: rtl/ars_key_scanner.sv
// Scalar key scanner for the point multiplier: it skips leading zeros and drops
// the leading one, then presents the remaining bits of k MSB-first under valid/step.
module ars_key_scanner #(
    parameter int KEY_W = 233,
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [KEY_W-1:0] KEY_IN,
    input  logic             KEY_LOAD,
    input  logic             STEP,
    output logic             KEY_EQ_1,
    output logic             BIT_VALID,
    output logic [IDX_W-1:0] BIT_INDEX,
    output logic             BUSY,
    output logic             DONE,
    output logic             KEY_ZERO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_READY = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   sr_q, sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               zero_q, zero_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        zero_d  = zero_q;

        // A load restarts from any state and takes precedence over STEP.
        if (KEY_LOAD) begin
            sr_d  = KEY_IN;
            idx_d = IDX_TOP;
            if (KEY_IN == '0) begin
                state_d = ST_FIN;
                zero_d  = 1'b1;
            end else begin
                state_d = ST_SEEK;
                zero_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_SEEK: begin
                    sr_d  = sr_q << 1;
                    idx_d = idx_q - IDX_ONE;
                    // The leading one is swallowed: the multiplier starts with Q = P.
                    if (sr_q[KEY_W-1]) begin
                        state_d = (idx_q == '0) ? ST_FIN : ST_READY;
                    end
                end
                ST_READY: begin
                    if (STEP) begin
                        sr_d  = sr_q << 1;
                        idx_d = idx_q - IDX_ONE;
                        if (idx_q == '0) begin
                            state_d = ST_FIN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign KEY_EQ_1  = sr_q[KEY_W-1];
    assign BIT_INDEX = idx_q;
    assign BIT_VALID = (state_q == ST_READY);
    assign BUSY      = (state_q == ST_SEEK) || (state_q == ST_READY);
    assign DONE      = (state_q == ST_FIN);
    assign KEY_ZERO  = zero_q;

endmodule
